// File: rtl/bit_serial_alu_seq_if.sv
// Request/result bundle for the bit-serial ALU sequencer.
// master: the requester; slave: the sequencer.
interface bit_serial_alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [2:0]       opsel;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             zero;
  logic             overflow;

  modport master (
    output start, opsel, opa, opb,
    input  busy, done, res, carry, zero, overflow
  );

  modport slave (
    input  start, opsel, opa, opb,
    output busy, done, res, carry, zero, overflow
  );
endinterface

// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds latched operands LSB-first through an external
// 1-bit ALU slice, one bit per clock, and assembles the result and ADD/SUB flags.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bit_serial_alu_seq_if.slave  bus,
  output logic                 alu_a,
  output logic                 alu_b,
  output logic                 alu_ainvert,
  output logic                 alu_binvert,
  output logic                 alu_carryin,
  output logic [1:0]           alu_op,
  input  logic                 alu_result,
  input  logic                 alu_cout
);

  localparam int unsigned     IdxW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic [IdxW-1:0]  idx_q;
  logic             cy_q;     // running carry between slice steps
  logic             carry_q;
  logic             ovf_q;

  logic legal, accept, last, arith;

  assign legal  = (bus.opsel <= 3'b101);
  assign accept = (state_q == StIdle) && bus.start && legal;
  assign last   = (idx_q == LastIdx);
  assign arith  = (op_q == 3'b010) || (op_q == 3'b011);

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.res      = res_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = (res_q == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one pass of WIDTH steps, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Slice drive: only active in RUN, quiet (all zero) otherwise.
  always_comb begin
    alu_a       = 1'b0;
    alu_b       = 1'b0;
    alu_ainvert = 1'b0;
    alu_binvert = 1'b0;
    alu_carryin = 1'b0;
    alu_op      = 2'b00;
    if (state_q == StRun) begin
      alu_a       = a_q[idx_q];
      alu_b       = b_q[idx_q];
      alu_carryin = arith & cy_q;
      case (op_q)
        3'b000: alu_op = 2'b00;
        3'b001: alu_op = 2'b01;
        3'b010: alu_op = 2'b10;
        3'b011: begin
          alu_binvert = 1'b1;
          alu_op      = 2'b10;
        end
        // NOR/NAND via De Morgan on inverted inputs.
        3'b100: begin
          alu_ainvert = 1'b1;
          alu_binvert = 1'b1;
          alu_op      = 2'b00;
        end
        3'b101: begin
          alu_ainvert = 1'b1;
          alu_binvert = 1'b1;
          alu_op      = 2'b01;
        end
        default: alu_op = 2'b00;
      endcase
    end
  end

  // Datapath: latch on accept, collect one result bit per RUN cycle, flags on last bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.opa;
      b_q     <= bus.opb;
      op_q    <= bus.opsel;
      idx_q   <= '0;
      cy_q    <= (bus.opsel == 3'b011);  // SUB is a + ~b + 1
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == StRun) begin
      res_q[idx_q] <= alu_result;
      idx_q        <= idx_q + IdxW'(1);
      if (arith) cy_q <= alu_cout;
      if (last) begin
        // cy_q still holds the carry into the MSB here.
        carry_q <= arith & alu_cout;
        ovf_q   <= arith & (alu_cout ^ cy_q);
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq (WIDTH=8) with a 1-bit ALU slice model.
module tb_bit_serial_alu_seq;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin;
  logic [1:0] alu_op;
  logic alu_result, alu_cout;
  logic sa, sb;

  int checks = 0;
  int errors = 0;

  bit_serial_alu_seq_if #(.WIDTH(W)) bus ();

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ainvert (alu_ainvert),
    .alu_binvert (alu_binvert),
    .alu_carryin (alu_carryin),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .alu_cout    (alu_cout)
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice.
  always_comb begin
    sa       = alu_a ^ alu_ainvert;
    sb       = alu_b ^ alu_binvert;
    alu_cout = (sa & sb) | (sa & alu_carryin) | (sb & alu_carryin);
    case (alu_op)
      2'b00:   alu_result = sa & sb;
      2'b01:   alu_result = sa | sb;
      2'b10:   alu_result = sa ^ sb ^ alu_carryin;
      default: alu_result = 1'b0;
    endcase
  end

  // Reference: {res, carry, overflow, zero} from plain arithmetic.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] s;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[7:0];
        c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'b011: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1;
        r = s[7:0];
        c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'b100:  r = ~(a | b);
      default: r = ~(a & b);
    endcase
    return {r, c, v, (r == 8'h00)};
  endfunction

  // Issue one op; returns at the negedge where done is seen (or after a cycle budget).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        output logic [10:0] got, output int lat, output logic [7:0] alu_snap);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = a;
    bus.opb   = b;
    bus.opsel = op;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      bus.opa   = 8'($urandom);
      bus.opb   = 8'($urandom);
      bus.opsel = 3'($urandom);
      @(negedge clk);
      lat++;
    end
    got      = {bus.res, bus.carry, bus.overflow, bus.zero};
    alu_snap = {alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op, bus.busy};
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.res, bus.carry, bus.overflow, bus.zero} !== 13'b00_00000000_001
        || {alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b res=%h c=%b v=%b z=%b alu=%b%b%b%b%b%b exp idle zeros z=1",
               bus.busy, bus.done, bus.res, bus.carry, bus.overflow, bus.zero,
               alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0]  va[9] = '{8'h3C, 8'h05, 8'h80, 8'h7F, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
    logic [7:0]  vb[9] = '{8'h0F, 8'h05, 8'h01, 8'h01, 8'h01, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
    logic [2:0]  vo[9] = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd4, 3'd5};
    logic [10:0] ve[9] = '{{8'h4B, 3'b000}, {8'h00, 3'b101}, {8'h7F, 3'b110},
                           {8'h80, 3'b010}, {8'h00, 3'b101}, {8'hC0, 3'b000},
                           {8'hFC, 3'b000}, {8'h03, 3'b000}, {8'h3F, 3'b000}};
    logic [10:0] got;
    logic [7:0]  snap;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(va[i], vb[i], vo[i], got, lat, snap);
      checks++;
      if (got !== ve[i] || lat !== 8) begin
        errors++;
        $display("FAIL directed[%0d]: res/c/v/z=%h/%b lat=%0d exp %h/%b lat=8",
                 i, got[10:3], got[2:0], lat, ve[i][10:3], ve[i][2:0]);
      end
      checks++;
      if (snap !== 8'b0000000_1) begin
        errors++;
        $display("FAIL done_alu_quiet[%0d]: alu/busy=%b exp 00000001", i, snap);
      end
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0
          || {bus.res, bus.carry, bus.overflow, bus.zero} !== ve[i]) begin
        errors++;
        $display("FAIL hold[%0d]: done=%b busy=%b res/flags=%h exp done=0 busy=0 %h",
                 i, bus.done, bus.busy, {bus.res, bus.carry, bus.overflow, bus.zero}, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] got, exp;
    logic [7:0]  a, b, snap;
    logic [2:0]  op;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      op  = 3'($urandom_range(0, 5));
      exp = model(a, b, op);
      run_op(a, b, op, got, lat, snap);
      checks++;
      if (got !== exp || lat !== 8) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat=%0d exp %h lat=8",
                 i, op, a, b, got, lat, exp);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [10:0] exp, got;
    int          ndone = 0;
    int          first = -1;
    exp = model(8'h12, 8'h34, 3'b010);
    got = '0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = 8'h12;
    bus.opb   = 8'h34;
    bus.opsel = 3'b010;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        bus.start = 1'b1;
        bus.opa   = 8'hAA;
        bus.opb   = 8'h55;
        bus.opsel = 3'b011;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        if (first < 0) first = c;
        got = {bus.res, bus.carry, bus.overflow, bus.zero};
      end
    end
    checks++;
    if (ndone !== 1 || first !== 8 || got !== exp) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d at=%0d res=%h exp dones=1 at=8 res=%h",
               ndone, first, got, exp);
    end
  endtask

  task automatic test_reset_midop();
    logic [10:0] got, exp;
    logic [7:0]  snap;
    int          lat;
    int          seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = 8'hFF;
    bus.opb   = 8'h00;
    bus.opsel = 3'b010;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.res, bus.carry, bus.overflow, bus.zero} !== 13'b00_00000000_001
        || {alu_a, alu_b, alu_ainvert, alu_binvert, alu_carryin, alu_op} !== 7'b0) begin
      errors++;
      $display("FAIL reset_midop: busy=%b done=%b res=%h c=%b v=%b z=%b exp 0 0 00 0 0 1",
               bus.busy, bus.done, bus.res, bus.carry, bus.overflow, bus.zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: active cycles=%0d exp 0", seen);
    end
    exp = model(8'hA7, 8'h3B, 3'b011);
    run_op(8'hA7, 8'h3B, 3'b011, got, lat, snap);
    checks++;
    if (got !== exp || lat !== 8) begin
      errors++;
      $display("FAIL after_reset: got %h lat=%0d exp %h lat=8", got, lat, exp);
    end
  endtask

  task automatic test_illegal();
    logic [10:0] got, prior;
    logic [7:0]  snap;
    logic [2:0]  bad[2] = '{3'b110, 3'b111};
    int          lat;
    int          wrong;
    run_op(8'h3C, 8'h0F, 3'b010, prior, lat, snap);
    for (int k = 0; k < 2; k++) begin
      wrong = 0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.opsel = bad[k];
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        got = {bus.res, bus.carry, bus.overflow, bus.zero};
        if (bus.busy || bus.done || got !== 11'h258) wrong++;
      end
      bus.start = 1'b0;
      checks++;
      if (wrong !== 0) begin
        errors++;
        $display("FAIL illegal_op[%0d]: bad cycles=%0d last res=%h exp 0 cycles res=258",
                 k, wrong, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got, exp;
    logic [7:0]  snap;
    int          lat;
    run_op(8'h55, 8'h66, 3'b010, got, lat, snap);
    bus.start = 1'b1;
    bus.opa   = 8'h90;
    bus.opb   = 8'h90;
    bus.opsel = 3'b010;
    exp = model(8'h90, 8'h90, 3'b010);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b exp 0", bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b exp 1", bus.busy);
    end
    lat = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = {bus.res, bus.carry, bus.overflow, bus.zero};
    checks++;
    if (got !== exp || lat !== 8) begin
      errors++;
      $display("FAIL b2b_result: got %h lat=%0d exp %h lat=8", got, lat, exp);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.opsel = '0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_midop();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
